bicubic_window_feeder: RTL

- Request-side initiator for the bicubic 4x4 upsample core.
- Accepts a raster-order single-channel pixel stream and keeps three previous image lines in line buffers.
- Builds a 4x4 sliding window (stride 1, no border padding) and presents it on the bf_req_valid / bcci_req_ready handshake.
- One instance per colour channel; sits between the frame input interface and the upsample core.

---
 rtl/bicubic_window_feeder_if.sv | 32 +++
 rtl/bicubic_window_feeder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/bicubic_window_feeder_if.sv
// Handshake bundle for the bicubic window feeder.
// Carries the pixel input stream and the 4x4 window request.
interface bicubic_window_feeder_if #(
    parameter int CHANNEL_WIDTH = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic [CHANNEL_WIDTH-1:0] in_data;
    logic                     bf_req_valid;
    logic                     bcci_req_ready;
    logic                     req_last;
    logic [CHANNEL_WIDTH-1:0] p1, p2, p3, p4;
    logic [CHANNEL_WIDTH-1:0] p5, p6, p7, p8;
    logic [CHANNEL_WIDTH-1:0] p9, p10, p11, p12;
    logic [CHANNEL_WIDTH-1:0] p13, p14, p15, p16;

    // Feeder side: consumes pixels, initiates window requests.
    modport master (
        input  in_valid, in_data, bcci_req_ready,
        output in_ready, bf_req_valid, req_last,
        output p1, p2, p3, p4, p5, p6, p7, p8,
        output p9, p10, p11, p12, p13, p14, p15, p16
    );

    // Environment side: pixel source and upsample core.
    modport slave (
        output in_valid, in_data, bcci_req_ready,
        input  in_ready, bf_req_valid, req_last,
        input  p1, p2, p3, p4, p5, p6, p7, p8,
        input  p9, p10, p11, p12, p13, p14, p15, p16
    );
endinterface

// File: rtl/bicubic_window_feeder.sv
// Bicubic window feeder: buffers three lines of a raster stream
// and issues 4x4 sliding windows to the upsample core.
module bicubic_window_feeder #(
    parameter int CHANNEL_WIDTH = 8,
    parameter int IMG_WIDTH     = 960,
    parameter int IMG_HEIGHT    = 540
) (
    input logic                     clk,
    input logic                     rst,
    bicubic_window_feeder_if.master bus
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    typedef logic [CHANNEL_WIDTH-1:0] pix_t;

    logic [CW-1:0] col_cnt_q, col_cnt_d;
    logic [RW-1:0] row_cnt_q, row_cnt_d;
    pix_t          win_q [4][4];
    pix_t          win_d [4][4];
    pix_t          p_q [16];
    pix_t          p_d [16];
    logic          valid_q, valid_d;
    logic          last_q, last_d;

    pix_t          lb0_mem [IMG_WIDTH];
    pix_t          lb1_mem [IMG_WIDTH];
    pix_t          lb2_mem [IMG_WIDTH];
    pix_t          new_col [4];

    logic          in_ready;
    logic          accept;
    logic          qualify;
    logic          col_end;
    logic          row_end;

    // Input may advance unless a window is stalled at the core.
    always_comb begin
        in_ready = !valid_q | bus.bcci_req_ready;
        accept   = bus.in_valid & in_ready;
        col_end  = (col_cnt_q == CW'(IMG_WIDTH - 1));
        row_end  = (row_cnt_q == RW'(IMG_HEIGHT - 1));
        qualify  = accept && (row_cnt_q >= RW'(3))
                          && (col_cnt_q >= CW'(3));
    end

    // Incoming column: oldest line at row 0, live pixel at row 3.
    always_comb begin
        new_col[0] = lb2_mem[col_cnt_q];
        new_col[1] = lb1_mem[col_cnt_q];
        new_col[2] = lb0_mem[col_cnt_q];
        new_col[3] = bus.in_data;
    end

    // Raster position counters; frames follow back to back.
    always_comb begin
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        if (accept) begin
            if (col_end) begin
                col_cnt_d = '0;
                row_cnt_d = row_end ? '0 : row_cnt_q + 1'b1;
            end else begin
                col_cnt_d = col_cnt_q + 1'b1;
            end
        end
    end

    // Shift the window left and append the new column.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][3] = new_col[r];
            end
        end
    end

    // Request register: load on a full window, clear on handoff.
    always_comb begin
        p_d     = p_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (qualify) begin
            valid_d = 1'b1;
            last_d  = row_end & col_end;
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    p_d[4*r+c] = win_d[r][c];
                end
            end
        end else if (valid_q && bus.bcci_req_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            for (int i = 0; i < 16; i++) begin
                p_q[i] <= '0;
            end
        end else begin
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            win_q     <= win_d;
            p_q       <= p_d;
        end
    end

    // Line buffers age one line per accept at the same column.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2_mem[col_cnt_q] <= lb1_mem[col_cnt_q];
            lb1_mem[col_cnt_q] <= lb0_mem[col_cnt_q];
            lb0_mem[col_cnt_q] <= bus.in_data;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.bf_req_valid = valid_q;
    assign bus.req_last     = last_q;
    assign bus.p1           = p_q[0];
    assign bus.p2           = p_q[1];
    assign bus.p3           = p_q[2];
    assign bus.p4           = p_q[3];
    assign bus.p5           = p_q[4];
    assign bus.p6           = p_q[5];
    assign bus.p7           = p_q[6];
    assign bus.p8           = p_q[7];
    assign bus.p9           = p_q[8];
    assign bus.p10          = p_q[9];
    assign bus.p11          = p_q[10];
    assign bus.p12          = p_q[11];
    assign bus.p13          = p_q[12];
    assign bus.p14          = p_q[13];
    assign bus.p15          = p_q[14];
    assign bus.p16          = p_q[15];
endmodule
